uart_rx: RTL and testbench

- Serial-to-parallel UART receiver. It is the receive-side counterpart of the team's UartTx: 8N1 framing, LSB first, idle-high line.
- Sits between the board RX pin and the byte-consuming logic.
- Presents each received byte with a one-clock done strobe.
- Flags frames whose stop bit is low.

---
 rtl/uart_rx_if.sv | 29 ++
 rtl/uart_rx.sv | 149 ++++++++++++++
 tb/tb_uart_rx.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - serial input, enable and received-byte signals of the UART receiver
interface uart_rx_if;
    logic       rxEnable;
    logic       uartRxBit;
    logic [7:0] uartOutByte;
    logic       uartRxDone;
    logic       uartFrameErr;
    logic       uartRxBusy;

    // Receiver side: samples the line, presents bytes and status.
    modport master (
        input  rxEnable,
        input  uartRxBit,
        output uartOutByte,
        output uartRxDone,
        output uartFrameErr,
        output uartRxBusy
    );

    // Consumer side: drives the line and enable, takes bytes and status.
    modport slave (
        output rxEnable,
        output uartRxBit,
        input  uartOutByte,
        input  uartRxDone,
        input  uartFrameErr,
        input  uartRxBusy
    );
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 oversampling UART receiver with done and frame-error strobes
module uart_rx #(
    parameter int CLKFREQ    = 100_000_000,
    parameter int BAUDRATE   = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic     clk,
    input  logic     reset,
    uart_rx_if.master rxIf
);
    localparam int DIV = CLKFREQ / (BAUDRATE * OVERSAMPLE);
    localparam int SW  = $clog2(OVERSAMPLE);
    localparam int TW  = $clog2(DIV);

    localparam logic [SW-1:0] SAMP_MID  = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] SAMP_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] START   = 3'd1;
    localparam logic [2:0] DATA    = 3'd2;
    localparam logic [2:0] STOP    = 3'd3;
    localparam logic [2:0] ERRWAIT = 3'd4;

    logic          rxMeta;
    logic          rxS;
    logic [2:0]    state;
    logic [TW-1:0] tickCnt;
    logic          tick;
    logic [SW-1:0] sampCnt;
    logic [2:0]    bitCnt;
    logic [7:0]    shiftReg;
    logic [7:0]    outByte;
    logic          rxDone;
    logic          frameErr;

    // Two-flop synchronizer for the asynchronous line; resets to the idle-high level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rxMeta <= 1'b1;
            rxS    <= 1'b1;
        end else begin
            rxMeta <= rxIf.uartRxBit;
            rxS    <= rxMeta;
        end
    end

    // Sample-tick divider, held at zero while idle so ticks line up with the start edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tickCnt <= '0;
        end else if (state == IDLE || !rxIf.rxEnable || tick) begin
            tickCnt <= '0;
        end else begin
            tickCnt <= tickCnt + 1'b1;
        end
    end

    assign tick = (tickCnt == TICK_LAST);

    // Frame state machine: start qualification, mid-bit data sampling, stop check.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            sampCnt  <= '0;
            bitCnt   <= '0;
            shiftReg <= '0;
            outByte  <= '0;
            rxDone   <= 1'b0;
            frameErr <= 1'b0;
        end else begin
            rxDone   <= 1'b0;
            frameErr <= 1'b0;
            if (!rxIf.rxEnable) begin
                state   <= IDLE;
                sampCnt <= '0;
                bitCnt  <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        sampCnt <= '0;
                        bitCnt  <= '0;
                        if (!rxS) begin
                            state <= START;
                        end
                    end
                    START: begin
                        if (tick) begin
                            if (sampCnt == SAMP_MID) begin
                                sampCnt <= '0;
                                // A line back high at mid start bit was only a glitch.
                                state   <= rxS ? IDLE : DATA;
                            end else begin
                                sampCnt <= sampCnt + 1'b1;
                            end
                        end
                    end
                    DATA: begin
                        if (tick) begin
                            if (sampCnt == SAMP_LAST) begin
                                sampCnt  <= '0;
                                shiftReg <= {rxS, shiftReg[7:1]};
                                if (bitCnt == 3'd7) begin
                                    bitCnt <= '0;
                                    state  <= STOP;
                                end else begin
                                    bitCnt <= bitCnt + 1'b1;
                                end
                            end else begin
                                sampCnt <= sampCnt + 1'b1;
                            end
                        end
                    end
                    STOP: begin
                        if (tick) begin
                            if (sampCnt == SAMP_LAST) begin
                                sampCnt <= '0;
                                if (rxS) begin
                                    outByte <= shiftReg;
                                    rxDone  <= 1'b1;
                                    state   <= IDLE;
                                end else begin
                                    frameErr <= 1'b1;
                                    state    <= ERRWAIT;
                                end
                            end else begin
                                sampCnt <= sampCnt + 1'b1;
                            end
                        end
                    end
                    ERRWAIT: begin
                        // Wait out a break so a held-low line is not taken as a new start.
                        if (rxS) begin
                            state <= IDLE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign rxIf.uartOutByte  = outByte;
    assign rxIf.uartRxDone   = rxDone;
    assign rxIf.uartFrameErr = frameErr;
    assign rxIf.uartRxBusy   = (state != IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx against a frame-timing model
module tb_uart_rx;
    localparam int CLKFREQ = 18_432_000;
    localparam int BAUD    = 115200;
    localparam int OS      = 16;
    localparam int DIV     = CLKFREQ / (BAUD * OS);
    localparam int BIT     = DIV * OS;
    // Start edge -> 2 sync clocks, 1 clock to leave idle, then half a start bit,
    // 8 data bits and one stop bit of sample ticks, pulse registered on the last tick.
    localparam int LAT     = 2 + 1 + (OS / 2 + 9 * OS) * DIV;

    typedef struct {
        int         cyc;
        bit         isErr;
        logic [7:0] data;
    } ev_t;

    logic clk;
    logic reset;
    int   cyc;
    int   checks;
    int   errors;
    ev_t  evQ[$];
    logic [7:0] modelByte;
    int   doneCnt;
    int   errCnt;
    int   lastDoneCyc;
    int   lastErrCyc;

    uart_rx_if u_if();

    uart_rx #(
        .CLKFREQ(CLKFREQ),
        .BAUDRATE(BAUD),
        .OVERSAMPLE(OS)
    ) dut (
        .clk(clk),
        .reset(reset),
        .rxIf(u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Per-cycle comparison of strobes and byte against the scheduled frame events.
    always @(negedge clk) begin
        logic expDone;
        logic expErr;
        expDone = 1'b0;
        expErr  = 1'b0;
        if (evQ.size() > 0 && evQ[0].cyc == cyc) begin
            if (evQ[0].isErr) begin
                expErr = 1'b1;
            end else begin
                expDone   = 1'b1;
                modelByte = evQ[0].data;
            end
            void'(evQ.pop_front());
        end
        if (u_if.uartRxDone) begin
            doneCnt++;
            lastDoneCyc = cyc;
        end
        if (u_if.uartFrameErr) begin
            errCnt++;
            lastErrCyc = cyc;
        end
        check("done", 32'(u_if.uartRxDone), 32'(expDone));
        check("frameErr", 32'(u_if.uartFrameErr), 32'(expErr));
        check("outByte", 32'(u_if.uartOutByte), 32'(modelByte));
    end

    task automatic driveBit(input logic b, input int n);
        u_if.uartRxBit = b;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Sends one frame; schedules a done (good stop) or error (low stop) event.
    task automatic sendFrame(input logic [7:0] d, input logic stopBit);
        ev_t e;
        e.cyc   = cyc + LAT;
        e.isErr = !stopBit;
        e.data  = d;
        evQ.push_back(e);
        driveBit(1'b0, BIT);
        for (int i = 0; i < 8; i++) driveBit(d[i], BIT);
        driveBit(stopBit, BIT);
    endtask

    initial begin
        int startCyc;
        int d0;
        int e0;
        int waitCnt;
        checks      = 0;
        errors      = 0;
        cyc         = 0;
        modelByte   = 8'h00;
        doneCnt     = 0;
        errCnt      = 0;
        lastDoneCyc = -1;
        lastErrCyc  = -1;
        reset          = 1'b0;
        u_if.rxEnable  = 1'b1;
        u_if.uartRxBit = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("rst_byte", 32'(u_if.uartOutByte), 32'h00);
        check("rst_done", 32'(u_if.uartRxDone), 32'h0);
        check("rst_err", 32'(u_if.uartFrameErr), 32'h0);
        check("rst_busy", 32'(u_if.uartRxBusy), 32'h0);
        reset = 1'b1;
        driveBit(1'b1, BIT);

        // Single frame with literal timing and value.
        startCyc = cyc;
        e0 = errCnt;
        sendFrame(8'hA5, 1'b1);
        check("a5_byte", 32'(u_if.uartOutByte), 32'hA5);
        check("a5_latency", 32'(lastDoneCyc - startCyc), 32'd1523);
        check("a5_noerr", 32'(errCnt - e0), 32'd0);
        driveBit(1'b1, BIT);

        // Back-to-back frames without an idle gap.
        d0 = doneCnt;
        sendFrame(8'h00, 1'b1);
        sendFrame(8'hFF, 1'b1);
        sendFrame(8'h3C, 1'b1);
        check("b2b_count", 32'(doneCnt - d0), 32'd3);
        check("b2b_last", 32'(u_if.uartOutByte), 32'h3C);
        driveBit(1'b1, BIT);

        // Start glitch: 40 clocks low, then high.
        d0 = doneCnt;
        e0 = errCnt;
        driveBit(1'b0, 20);
        check("glitch_busy", 32'(u_if.uartRxBusy), 32'h1);
        driveBit(1'b0, 20);
        u_if.uartRxBit = 1'b1;
        waitCnt = 0;
        while (u_if.uartRxBusy && waitCnt < 81) begin
            @(posedge clk);
            #1;
            waitCnt++;
        end
        check("glitch_busy_drop", 32'(u_if.uartRxBusy), 32'h0);
        driveBit(1'b1, BIT);
        check("glitch_nopulse", 32'((doneCnt - d0) + (errCnt - e0)), 32'd0);
        sendFrame(8'h55, 1'b1);
        check("after_glitch", 32'(u_if.uartOutByte), 32'h55);
        driveBit(1'b1, BIT);

        // Low stop bit, line held low one more bit period.
        startCyc = cyc;
        sendFrame(8'h81, 1'b0);
        driveBit(1'b0, BIT);
        check("ferr_cycle", 32'(lastErrCyc - startCyc), 32'd1523);
        check("ferr_keep", 32'(u_if.uartOutByte), 32'h55);
        driveBit(1'b1, BIT);
        sendFrame(8'h7E, 1'b1);
        check("after_ferr", 32'(u_if.uartOutByte), 32'h7E);
        driveBit(1'b1, BIT);

        // Enable dropped in the middle of data bit 4.
        d0 = doneCnt;
        e0 = errCnt;
        driveBit(1'b0, BIT);
        for (int i = 0; i < 4; i++) driveBit(1'(8'hB6 >> i), BIT);
        driveBit(1'b0, BIT / 2);
        check("abort_busy_before", 32'(u_if.uartRxBusy), 32'h1);
        u_if.rxEnable = 1'b0;
        @(posedge clk);
        #1;
        check("abort_busy", 32'(u_if.uartRxBusy), 32'h0);
        driveBit(1'b0, BIT / 2 - 1);
        for (int i = 5; i < 8; i++) driveBit(1'(8'hB6 >> i), BIT);
        driveBit(1'b1, BIT);
        check("abort_nopulse", 32'((doneCnt - d0) + (errCnt - e0)), 32'd0);
        u_if.rxEnable = 1'b1;
        driveBit(1'b1, BIT);
        sendFrame(8'h12, 1'b1);
        check("after_abort", 32'(u_if.uartOutByte), 32'h12);
        driveBit(1'b1, BIT);

        // Asynchronous reset in the middle of a frame.
        driveBit(1'b0, BIT);
        for (int i = 0; i < 3; i++) driveBit(1'(8'hC3 >> i), BIT);
        #2;
        reset     = 1'b0;
        modelByte = 8'h00;
        #1;
        check("mrst_byte", 32'(u_if.uartOutByte), 32'h00);
        check("mrst_done", 32'(u_if.uartRxDone), 32'h0);
        check("mrst_err", 32'(u_if.uartFrameErr), 32'h0);
        check("mrst_busy", 32'(u_if.uartRxBusy), 32'h0);
        u_if.uartRxBit = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        driveBit(1'b1, BIT);
        sendFrame(8'hC3, 1'b1);
        check("after_reset", 32'(u_if.uartOutByte), 32'hC3);
        driveBit(1'b1, BIT);

        check("events_drained", 32'(evQ.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
